// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads a combinational imem and buffers {pc, instr} for decode.
// One cycle from PC to valid_o; decode stalls via ready_i fill the buffer, after which fetch holds the PC.
module fetch_unit #(
    parameter int unsigned             DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]   RESET_PC   = '0,
    parameter int unsigned             FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_instr_i,
    input  logic                  halt_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [31:0]           fetch_cnt_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] pc_q;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [DATA_WIDTH-1:0] pc_mem    [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] instr_mem [FIFO_DEPTH];

    logic empty;
    logic full;
    logic pop;
    logic push;

    assign empty       = (count == '0);
    assign full        = (count == CNT_W'(FIFO_DEPTH));
    // A redirect hides the stale head so decode never consumes a wrong-path entry.
    assign valid_o     = !empty && !redirect_i;
    assign pop         = valid_o && ready_i;
    assign push        = !halt_i && !redirect_i && (!full || pop);
    assign imem_addr_o = pc_q;
    assign instr_o     = empty ? '0 : instr_mem[rd_ptr];
    assign pc_o        = empty ? '0 : pc_mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect_i) begin
            pc_q   <= {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                pc_q   <= pc_q + DATA_WIDTH'(4);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_o <= '0;
        end else if (pop) begin
            fetch_cnt_o <= fetch_cnt_o + 32'd1;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= pc_q;
            instr_mem[wr_ptr] <= imem_instr_i;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised and directed bench for fetch_unit against a queue-based reference model.
module tb_fetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        halt;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        valid;
    logic        ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] fetch_cnt;

    logic [31:0] imem_addr2;
    logic [31:0] imem_instr2;
    logic        valid2;
    logic [31:0] instr2;
    logic [31:0] pc2;
    logic [31:0] fetch_cnt2;
    logic        halt2;
    logic        redirect2;
    logic [31:0] redirect_pc2;
    logic        ready2;

    int n_pass;
    int n_total;

    entry_t      m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    function automatic logic [31:0] imem(input logic [31:0] a);
        logic [31:0] k;
        k = (a >> 2) + 32'd1;
        return (k << 20) | ((k & 32'd31) << 7) | 32'h13;
    endfunction

    assign imem_instr   = imem(imem_addr);
    assign imem_instr2  = imem(imem_addr2);
    assign halt2        = 1'b0;
    assign redirect2    = 1'b0;
    assign redirect_pc2 = 32'h0;
    assign ready2       = 1'b1;

    fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'h0), .FIFO_DEPTH(2)) u_dut (
        .clk(clk), .rst(rst),
        .imem_addr_o(imem_addr), .imem_instr_i(imem_instr),
        .halt_i(halt), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .valid_o(valid), .ready_i(ready),
        .instr_o(instr), .pc_o(pc), .fetch_cnt_o(fetch_cnt)
    );

    fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) u_dut_wrap (
        .clk(clk), .rst(rst),
        .imem_addr_o(imem_addr2), .imem_instr_i(imem_instr2),
        .halt_i(halt2), .redirect_i(redirect2), .redirect_pc_i(redirect_pc2),
        .valid_o(valid2), .ready_i(ready2),
        .instr_o(instr2), .pc_o(pc2), .fetch_cnt_o(fetch_cnt2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: evaluated mid-cycle, then advanced to the state after the coming edge.
    always @(negedge clk) begin
        logic exp_v;
        logic do_pop;
        logic do_push;
        if (rst) begin
            chk("rst_valid", {31'b0, valid}, 32'h0);
            chk("rst_addr", imem_addr, 32'h0);
            chk("rst_cnt", fetch_cnt, 32'h0);
            m_q.delete();
            m_pc  = 32'h0;
            m_cnt = 32'h0;
        end else begin
            exp_v = (m_q.size() != 0) && !redirect;
            chk("m_valid", {31'b0, valid}, {31'b0, exp_v});
            if (exp_v) begin
                chk("m_pc", pc, m_q[0].pc);
                chk("m_instr", instr, m_q[0].instr);
            end else if (m_q.size() == 0) begin
                chk("m_pc_empty", pc, 32'h0);
                chk("m_instr_empty", instr, 32'h0);
            end
            chk("m_addr", imem_addr, m_pc);
            chk("m_cnt", fetch_cnt, m_cnt);

            do_pop  = exp_v && ready;
            do_push = !halt && !redirect && (m_q.size() < 2 || do_pop);
            if (redirect) begin
                m_q.delete();
                m_pc = {redirect_pc[31:2], 2'b00};
            end else begin
                if (do_pop) begin
                    void'(m_q.pop_front());
                    m_cnt = m_cnt + 32'd1;
                end
                if (do_push) begin
                    m_q.push_back('{pc: m_pc, instr: imem(m_pc)});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_pass      = 0;
        n_total     = 0;
        rst         = 1'b1;
        ready       = 1'b1;
        halt        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;

        // Reset values and first-fetch latency
        step(); settle();
        chk("reset_valid", {31'b0, valid}, 32'h0);
        chk("reset_pc_o", pc, 32'h0);
        chk("reset_instr_o", instr, 32'h0);
        chk("reset_addr", imem_addr, 32'h0);
        chk("reset_addr_wrap", imem_addr2, 32'hFFFF_FFF8);
        step(); rst = 1'b0; settle();
        chk("first_cycle_valid", {31'b0, valid}, 32'h0);
        step(); settle();
        chk("second_cycle_valid", {31'b0, valid}, 32'h1);
        chk("seq_pc0", pc, 32'h0);
        chk("seq_instr0", instr, 32'h0010_0093);
        chk("wrap_pc0", pc2, 32'hFFFF_FFF8);
        step(); settle();
        chk("seq_pc4", pc, 32'h4);
        chk("seq_instr4", instr, 32'h0020_0113);
        chk("wrap_pc1", pc2, 32'hFFFF_FFFC);
        step(); settle();
        chk("seq_pc8", pc, 32'h8);
        chk("wrap_pc2", pc2, 32'h0);

        // Stall from reset: buffer fills, PC parks at 8, head holds
        rst = 1'b1; ready = 1'b0;
        step(); rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(); settle();
            chk("stall_pc_stable", pc, 32'h0);
        end
        chk("stall_addr", imem_addr, 32'h8);
        chk("stall_instr", instr, 32'h0010_0093);
        ready = 1'b1; settle();
        chk("resume_pc0", pc, 32'h0);
        step(); settle();
        chk("resume_pc4", pc, 32'h4);
        step(); settle();
        chk("resume_pc8", pc, 32'h8);
        chk("resume_cnt", fetch_cnt, 32'd2);

        // Redirect with a full buffer
        ready = 1'b0;
        step(); step(); step();
        redirect = 1'b1; redirect_pc = 32'h1E; settle();
        chk("redir_valid_n", {31'b0, valid}, 32'h0);
        step(); redirect = 1'b0; ready = 1'b1; settle();
        chk("redir_valid_n1", {31'b0, valid}, 32'h0);
        chk("redir_addr", imem_addr, 32'h1C);
        step(); settle();
        chk("redir_valid_n2", {31'b0, valid}, 32'h1);
        chk("redir_pc", pc, 32'h1C);
        chk("redir_instr", instr, 32'h0080_0413);
        chk("redir_cnt", fetch_cnt, 32'd2);

        // Halt with one entry buffered
        halt = 1'b1;
        step(); settle();
        chk("halt_valid", {31'b0, valid}, 32'h0);
        chk("halt_addr", imem_addr, 32'h20);
        chk("halt_cnt", fetch_cnt, 32'd3);
        step(); settle();
        chk("halt_addr_frozen", imem_addr, 32'h20);
        halt = 1'b0;
        step(); settle();
        chk("unhalt_valid", {31'b0, valid}, 32'h1);
        chk("unhalt_pc", pc, 32'h20);

        // Reset mid-stream with full buffer and count 7
        for (int i = 0; i < 40 && m_cnt != 32'd7; i++) step();
        chk("cnt_reached_7", m_cnt, 32'd7);
        ready = 1'b0;
        step(); step();
        chk("pre_rst_cnt", fetch_cnt, 32'd7);
        chk("pre_rst_valid", {31'b0, valid}, 32'h1);
        rst = 1'b1; settle();
        chk("midrst_valid", {31'b0, valid}, 32'h0);
        chk("midrst_cnt", fetch_cnt, 32'h0);
        chk("midrst_addr", imem_addr, 32'h0);
        step(); rst = 1'b0;

        // Random traffic checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            step();
            ready       = ($urandom % 4) != 0;
            halt        = ($urandom % 6) == 0;
            redirect    = ($urandom % 12) == 0;
            redirect_pc = $urandom;
            rst         = ($urandom % 400) == 0;
        end
        step();
        rst = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
